pattern_tx_11011: RTL and testbench
===================================

PATTERN_TX_11011 -- requirements
Module: pattern_tx_11011

Interface
REQ-001 The block SHALL have the following ports, clock and reset first.
- clk  input  1  single clock, all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a frame, sampled only in IDLE.
- count  input  4  number of 11011 occurrences in the frame (0-15), captured on accepted start.
- overlap  input  1  frame mode, captured on accepted start.
- signal  output  1  serial bit stream.
- valid  output  1  signal carries a frame bit this cycle.
- hit  output  1  expected overlapping-Mealy 11011 detection; high on the cycle signal carries the final 1 of an occurrence.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame end.

Function
REQ-002 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-003 States SHALL be IDLE, SEND, GAP and DONE.
REQ-004 In IDLE, start=1 at a rising edge SHALL be accepted and SHALL latch count and overlap.
- count!=0: go to SEND.
- count==0: go to DONE.
REQ-005 start SHALL be ignored in SEND, GAP and DONE, and latched count/overlap SHALL NOT change mid-frame.
REQ-006 The first frame bit SHALL appear on signal, with valid=1, in the cycle immediately after the accepting edge (latency 1).
REQ-007 Occurrence 1 SHALL emit 1,1,0,1,1, MSB first, one bit per cycle.
REQ-008 overlap=1: each further occurrence SHALL emit only 0,1,1, reusing the trailing 11 of the previous one.
- Frame length: 5+3*(count-1) bits, e.g. count=3 -> 11011011011.
REQ-009 overlap=0: each further occurrence SHALL be preceded by GAP emitting 0,0 with valid=1, then 1,1,0,1,1.
- Frame length: 7*count-2 bits.
- The 00 separator SHALL prevent any spurious 11011 across the boundary.
REQ-010 hit SHALL be 1 exactly on the cycle the last bit of each occurrence is on signal, so a frame produces exactly count hit pulses in either mode.
REQ-011 After the last bit of the frame, the block SHALL enter DONE for one cycle.
- DONE: done=1, valid=0, signal=0, busy=1.
- Then return to IDLE.
REQ-012 busy SHALL be 1 from the cycle after the accepting edge through the DONE cycle inclusive, and 0 in IDLE.
REQ-013 Outside SEND/GAP, signal, valid and hit SHALL be 0.
REQ-014 start held high continuously SHALL start a new frame on the first IDLE cycle after DONE, giving one idle cycle between frames.
REQ-015 The internal occurrence counter SHALL be 4 bits, decrement once per completed occurrence, and never wrap.
- count=15 SHALL produce exactly 15 occurrences.

Reset
REQ-016 rst=1 SHALL immediately, without waiting for clk, force state IDLE and signal=0, valid=0, hit=0, busy=0, done=0, and clear the latched count/overlap and bit counters.
REQ-017 Reset asserted mid-frame SHALL abort the frame with no done pulse.
- After release, the block SHALL accept a new start normally.
REQ-018 start present in the first edge after reset release SHALL be accepted.

Verification
REQ-019 Bench SHALL cover the following directed scenarios.
- count=1, overlap=x, start pulse -> signal 11011 over 5 cycles, valid=1 throughout, hit on cycle 5 only, done pulse on cycle 6, busy cycles 1-6.
- count=3, overlap=1 -> 11011011011 (11 bits), hit on bits 5, 8 and 11, then done.
- count=2, overlap=0 -> 110110011011 (12 bits), hit on bits 5 and 12 only, valid=1 during the 00 gap.
- count=0 -> no valid bits, done pulse on the cycle after the accepting edge, busy for that single cycle.
- Reset during bit 4 of a count=3 frame -> all outputs 0 immediately, no done pulse; a fresh start with count=1 then yields a clean 11011.
- Start pulsed while busy and start held high -> mid-frame start ignored; held start relaunches one cycle after DONE.
- Every frame SHALL also be fed into the team's overlapping Mealy 11011 detector, and its out SHALL match hit cycle-for-cycle.

Source files
------------

// File: rtl/pattern_tx_11011.sv
// Serial 11011 frame generator: emits `count` occurrences, either overlapped
// (each extra occurrence reuses the trailing 11) or separated by a 00 gap.
module pattern_tx_11011 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] count,
  input  logic       overlap,
  output logic       signal,
  output logic       valid,
  output logic       hit,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [4:0] PAT = 5'b11011;

  state_t     state;
  logic [3:0] occ_left;  // occurrences still to finish, including the one on the wire
  logic       ovl;
  logic [2:0] pos;       // index into PAT of the bit currently on signal
  logic       gap_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      occ_left <= '0;
      ovl      <= 1'b0;
      pos      <= '0;
      gap_pos  <= 1'b0;
      signal   <= 1'b0;
      valid    <= 1'b0;
      hit      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      hit  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          signal <= 1'b0;
          valid  <= 1'b0;
          busy   <= 1'b0;
          if (start) begin
            occ_left <= count;
            ovl      <= overlap;
            busy     <= 1'b1;
            if (count == 4'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state  <= SEND;
              pos    <= 3'd0;
              signal <= PAT[4];
              valid  <= 1'b1;
            end
          end
        end
        SEND: begin
          if (pos != 3'd4) begin
            pos    <= pos + 3'd1;
            signal <= PAT[3'd3 - pos];
            valid  <= 1'b1;
            hit    <= (pos == 3'd3);
          end else begin
            // Last bit of an occurrence just left the wire.
            occ_left <= occ_left - 4'd1;
            if (occ_left == 4'd1) begin
              state  <= DONE;
              signal <= 1'b0;
              valid  <= 1'b0;
              done   <= 1'b1;
            end else if (ovl) begin
              pos    <= 3'd2;
              signal <= PAT[2];
              valid  <= 1'b1;
            end else begin
              state   <= GAP;
              gap_pos <= 1'b0;
              signal  <= 1'b0;
              valid   <= 1'b1;
            end
          end
        end
        GAP: begin
          valid <= 1'b1;
          if (!gap_pos) begin
            gap_pos <= 1'b1;
            signal  <= 1'b0;
          end else begin
            state  <= SEND;
            pos    <= 3'd0;
            signal <= PAT[4];
          end
        end
        DONE: begin
          state  <= IDLE;
          signal <= 1'b0;
          valid  <= 1'b0;
          busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_tx_11011.sv
// Directed bench for pattern_tx_11011: frame-level queue model plus an
// overlapping Mealy 11011 detector, checked every cycle, with literal frame checks.
module tb_pattern_tx_11011;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] count;
  logic       overlap;
  logic       signal, valid, hit, busy, done;

  int tests = 0;
  int fails = 0;

  pattern_tx_11011 dut (
    .clk(clk), .rst(rst), .start(start), .count(count), .overlap(overlap),
    .signal(signal), .valid(valid), .hit(hit), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic sig; logic vld; logic hit; logic busy; logic done;} exp_t;
  exp_t q[$];

  function automatic void push_bits(input logic [6:0] b, input int len);
    exp_t e;
    for (int i = len - 1; i >= 0; i--) begin
      e = '{sig: b[i], vld: 1'b1, hit: (i == 0 && b[0] == 1'b1 && len != 2), busy: 1'b1, done: 1'b0};
      q.push_back(e);
    end
  endfunction

  // Frame built from its textual definition; hit marks the end of each occurrence.
  function automatic void push_frame(input logic [3:0] c, input logic o);
    exp_t e;
    for (int k = 0; k < int'(c); k++) begin
      if (k == 0)  push_bits(7'b0011011, 5);
      else if (o)  push_bits(7'b0000011, 3);
      else begin
        push_bits(7'b0000000, 2);
        push_bits(7'b0011011, 5);
      end
    end
    e = '{sig: 1'b0, vld: 1'b0, hit: 1'b0, busy: 1'b1, done: 1'b1};
    q.push_back(e);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) q.delete();
    else if (q.size() == 0) begin
      if (start) push_frame(count, overlap);
    end else void'(q.pop_front());
  end

  // Overlapping Mealy 11011 detector fed by the serial stream.
  logic [3:0] hist;
  logic       det;
  always @(posedge clk or posedge rst) begin
    if (rst) hist <= '0;
    else     hist <= {hist[2:0], signal & valid};
  end
  assign det = valid && ({hist, signal} == 5'b11011);

  always @(negedge clk) begin
    exp_t e;
    e = (q.size() != 0) ? q[0] : '0;
    tests++;
    if ({signal, valid, hit, busy, done} !== e) begin
      fails++;
      $display("FAIL cycle_model t=%0t got sig/vld/hit/busy/done=%b required %b", $time,
               {signal, valid, hit, busy, done}, e);
    end
    tests++;
    if (hit !== det) begin
      fails++;
      $display("FAIL mealy_detector t=%0t hit=%b detector=%b", $time, hit, det);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [3:0] c, input logic o);
    @(negedge clk);
    start = 1'b1; count = c; overlap = o;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge showing the first post-accept cycle; returns at the done cycle.
  task automatic collect(input int poke_at, output logic [127:0] bits, output logic [127:0] hits,
                         output int n, output int nhit, output int done_cyc, output bit got_done);
    bits = '0; hits = '0; n = 0; nhit = 0; done_cyc = -1; got_done = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (valid) begin
        bits = {bits[126:0], signal};
        hits = {hits[126:0], hit};
        n++;
        if (hit) nhit++;
      end
      if (done) begin
        got_done = 1'b1;
        done_cyc = cyc;
        break;
      end
      if (poke_at >= 0) begin
        start = (n == poke_at);
        if (n == poke_at) count = 4'd0;
      end
      @(negedge clk);
    end
    if (poke_at >= 0) start = 1'b0;
  endtask

  logic [127:0] bits, hits;
  int n, nhit, dcyc;
  bit gd;

  initial begin
    rst = 1'b1; start = 1'b1; count = 4'd1; overlap = 1'b0;
    #2;
    chk("reset_outputs", {signal, valid, hit, busy, done}, 5'b0);
    @(negedge clk);
    rst = 1'b0;                      // start already high on first edge after release
    @(negedge clk);
    start = 1'b0;
    collect(-1, bits, hits, n, nhit, dcyc, gd);
    chk("post_reset_start_bits", bits, 128'b11011);
    chk("post_reset_start_len", n, 5);

    launch(4'd1, 1'b1);
    collect(-1, bits, hits, n, nhit, dcyc, gd);
    chk("c1_bits", bits, 128'b11011);
    chk("c1_hits", hits, 128'b00001);
    chk("c1_done_cycle", dcyc, 5);

    launch(4'd3, 1'b1);
    collect(-1, bits, hits, n, nhit, dcyc, gd);
    chk("c3_ovl_bits", bits, 128'b11011011011);
    chk("c3_ovl_hits", hits, 128'b00001001001);
    chk("c3_ovl_len", n, 11);
    chk("c3_ovl_done", gd, 1);

    launch(4'd2, 1'b0);
    collect(-1, bits, hits, n, nhit, dcyc, gd);
    chk("c2_gap_bits", bits, 128'b110110011011);
    chk("c2_gap_hits", hits, 128'b000010000001);
    chk("c2_gap_len", n, 12);

    launch(4'd0, 1'b0);
    collect(-1, bits, hits, n, nhit, dcyc, gd);
    chk("c0_len", n, 0);
    chk("c0_done_cycle", dcyc, 0);
    chk("c0_busy_in_done", busy, 1);

    launch(4'd15, 1'b1);
    collect(-1, bits, hits, n, nhit, dcyc, gd);
    chk("c15_ovl_len", n, 47);
    chk("c15_ovl_hits", nhit, 15);

    launch(4'd15, 1'b0);
    collect(-1, bits, hits, n, nhit, dcyc, gd);
    chk("c15_gap_len", n, 103);
    chk("c15_gap_hits", nhit, 15);

    // Reset while bit 4 of a count=3 frame is on the wire.
    launch(4'd3, 1'b1);
    repeat (3) @(negedge clk);
    chk("bit4_before_reset", {signal, valid}, 2'b11);
    #1 rst = 1'b1;
    #1 chk("async_reset_outputs", {signal, valid, hit, busy, done}, 5'b0);
    @(negedge clk);
    chk("no_done_in_reset", done, 0);
    rst = 1'b0;
    launch(4'd1, 1'b0);
    collect(-1, bits, hits, n, nhit, dcyc, gd);
    chk("after_abort_bits", bits, 128'b11011);

    // Start pulsed mid-frame with count=0 must not disturb the frame.
    launch(4'd2, 1'b0);
    collect(3, bits, hits, n, nhit, dcyc, gd);
    chk("midframe_start_bits", bits, 128'b110110011011);

    // Held start: one idle cycle after DONE, then a new frame.
    @(negedge clk);
    start = 1'b1; count = 4'd1; overlap = 1'b0;
    @(negedge clk);
    collect(-1, bits, hits, n, nhit, dcyc, gd);
    chk("held_first_bits", bits, 128'b11011);
    @(negedge clk);
    chk("held_idle_gap", {busy, valid}, 2'b00);
    @(negedge clk);
    chk("held_relaunch", {busy, valid, signal}, 3'b111);
    start = 1'b0;
    begin
      int k;
      k = 0;
      while (busy && k < 50) begin
        @(negedge clk);
        k++;
      end
    end
    chk("held_second_finishes", busy, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
